// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline types: ALU/branch opcodes and the ID/EX and EX/MEM register layouts.
package rv32_pkg;

    localparam int DIV_ITER = 32;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
    } br_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        br_op_e      br_op;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic [4:0]  rd_addr;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        valid;
    } id_ex_pipeline_reg_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        valid;
    } ex_mem_pipeline_reg_t;

    function automatic logic is_div_op(input alu_op_e op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Compiled only when RV32_DIV_EN is defined.
`ifdef RV32_DIV_EN
module serial_divider
    import rv32_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        rem_sel_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d, den_q, den_d, rem_q, rem_d, res_q, res_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, rem_sel_q, rem_sel_d;
    logic        a_neg, b_neg;
    logic [32:0] rem_shift, rem_diff;
    logic [31:0] quo_next, rem_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        a_neg     = signed_i & dividend_i[31];
        b_neg     = signed_i & divisor_i[31];
        rem_shift = {rem_q, quo_q[31]};
        rem_diff  = rem_shift - {1'b0, den_q};
        if (rem_diff[32]) begin
            rem_next = rem_shift[31:0];
            quo_next = {quo_q[30:0], 1'b0};
        end else begin
            rem_next = rem_diff[31:0];
            quo_next = {quo_q[30:0], 1'b1};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        den_d     = den_q;
        res_d     = res_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_sel_d = rem_sel_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_sel_d = rem_sel_i;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    quo_d     = a_neg ? -dividend_i : dividend_i;
                    den_d     = b_neg ? -divisor_i : divisor_i;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (divisor_i == '0) begin
                        res_d   = rem_sel_i ? dividend_i : 32'hFFFF_FFFF;
                        state_d = DONE;
                    end else if (signed_i && dividend_i == 32'h8000_0000 && divisor_i == 32'hFFFF_FFFF) begin
                        res_d   = rem_sel_i ? 32'h0 : 32'h8000_0000;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITER - 1)) begin
                    res_d = rem_sel_q ? (neg_rem_q ? -rem_next : rem_next)
                                      : (neg_quo_q ? -quo_next : quo_next);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!stall_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            den_q     <= '0;
            res_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            den_q     <= den_d;
            res_q     <= res_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_sel_q <= rem_sel_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE) & ~stall_i & ~flush_i;
    assign result_o = res_q;
    assign state_o  = state_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// rv32 execute stage: ALU, branch/jump resolution and the EX/MEM pipeline register.
// Define RV32_DIV_EN to build in the serial divider for DIV/DIVU/REM/REMU.
module ex_stage
    import rv32_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  id_ex_pipeline_reg_t  id_ex_i,
    input  logic                 mem_stall_i,
    input  logic                 flush_i,
    output ex_mem_pipeline_reg_t ex_mem_o,
    output logic                 ex_busy_o,
    output logic                 redirect_o,
    output logic [31:0]          redirect_pc_o
);

    logic [31:0] op_a, op_b, alu_res, result, target, div_result;
    logic [63:0] mul_a, mul_b, mul_prod;
    logic [4:0]  shamt;
    logic        br_cond, take_redirect, div_stall;

    ex_mem_pipeline_reg_t ex_mem_q, ex_mem_d, ex_mem_calc;
    logic                 redirect_q, redirect_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;

`ifdef RV32_DIV_EN
    logic       div_op, div_busy, div_done;
    logic [1:0] div_state_unused;

    assign div_op = id_ex_i.valid & is_div_op(id_ex_i.alu_op);

    serial_divider u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (div_op & ~div_busy & ~flush_i),
        .signed_i   (id_ex_i.alu_op inside {ALU_DIV, ALU_REM}),
        .rem_sel_i  (id_ex_i.alu_op inside {ALU_REM, ALU_REMU}),
        .flush_i    (flush_i),
        .stall_i    (mem_stall_i),
        .dividend_i (op_a),
        .divisor_i  (op_b),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .result_o   (div_result),
        .state_o    (div_state_unused)
    );

    // A flushed divide is dead, so it must not hold the front end.
    assign div_stall = div_op & ~div_done & ~flush_i;
`else
    assign div_result = 32'h0;
    assign div_stall  = 1'b0;
`endif

    always_comb begin
        op_a     = id_ex_i.rs1_data;
        op_b     = id_ex_i.alu_src_imm ? id_ex_i.imm : id_ex_i.rs2_data;
        shamt    = op_b[4:0];
        mul_a    = (id_ex_i.alu_op inside {ALU_MULH, ALU_MULHSU}) ? {{32{op_a[31]}}, op_a} : {32'h0, op_a};
        mul_b    = (id_ex_i.alu_op == ALU_MULH) ? {{32{op_b[31]}}, op_b} : {32'h0, op_b};
        mul_prod = mul_a * mul_b;
        alu_res  = '0;
        case (id_ex_i.alu_op)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_SLL:    alu_res = op_a << shamt;
            ALU_SRL:    alu_res = op_a >> shamt;
            ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:    alu_res = {31'h0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {31'h0, op_a < op_b};
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_OR:     alu_res = op_a | op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_LUI:    alu_res = id_ex_i.imm;
            ALU_AUIPC:  alu_res = id_ex_i.pc + id_ex_i.imm;
            ALU_MUL:    alu_res = mul_prod[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_res = mul_prod[63:32];
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_res = div_result;
            default:    alu_res = '0;
        endcase
    end

    always_comb begin
        case (id_ex_i.br_op)
            BR_BEQ:  br_cond = (id_ex_i.rs1_data == id_ex_i.rs2_data);
            BR_BNE:  br_cond = (id_ex_i.rs1_data != id_ex_i.rs2_data);
            BR_BLT:  br_cond = ($signed(id_ex_i.rs1_data) < $signed(id_ex_i.rs2_data));
            BR_BGE:  br_cond = ($signed(id_ex_i.rs1_data) >= $signed(id_ex_i.rs2_data));
            BR_BLTU: br_cond = (id_ex_i.rs1_data < id_ex_i.rs2_data);
            BR_BGEU: br_cond = (id_ex_i.rs1_data >= id_ex_i.rs2_data);
            default: br_cond = 1'b0;
        endcase
        target        = id_ex_i.jalr ? ((id_ex_i.rs1_data + id_ex_i.imm) & ~32'h1)
                                     : (id_ex_i.pc + id_ex_i.imm);
        take_redirect = id_ex_i.valid &
                        ((id_ex_i.branch & br_cond) | id_ex_i.jump | id_ex_i.jalr);
        result        = (id_ex_i.jump | id_ex_i.jalr) ? id_ex_i.pc + 32'd4 : alu_res;

        ex_mem_calc.alu_result = result;
        ex_mem_calc.rs2_data   = id_ex_i.rs2_data;
        ex_mem_calc.rd_addr    = id_ex_i.rd_addr;
        ex_mem_calc.mem_read   = id_ex_i.mem_read;
        ex_mem_calc.mem_write  = id_ex_i.mem_write;
        ex_mem_calc.reg_write  = id_ex_i.reg_write & ~id_ex_i.branch;
        ex_mem_calc.valid      = id_ex_i.valid;
    end

    // Flush beats stall; a stall holds everything and lets redirect drop back low.
    always_comb begin
        ex_mem_d      = ex_mem_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (flush_i) begin
            ex_mem_d       = ex_mem_calc;
            ex_mem_d.valid = 1'b0;
        end else if (!mem_stall_i) begin
            if (div_stall) begin
                ex_mem_d = '0;
            end else begin
                ex_mem_d   = ex_mem_calc;
                redirect_d = take_redirect;
                if (take_redirect) redirect_pc_d = target;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_mem_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            ex_mem_q      <= ex_mem_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign ex_mem_o      = ex_mem_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign ex_busy_o     = mem_stall_i | div_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table for single-cycle ops, hand sequences for stall,
// flush, reset and (with RV32_DIV_EN) the serial divider.
module tb_ex_stage;
    import rv32_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    id_ex_pipeline_reg_t  id_ex = '0;
    logic                 mem_stall = 1'b0;
    logic                 flush = 1'b0;
    ex_mem_pipeline_reg_t ex_mem;
    logic                 ex_busy, redirect;
    logic [31:0]          redirect_pc;

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    typedef struct {
        id_ex_pipeline_reg_t stim;
        exp_t                ex;
    } vec_t;

    exp_t exp_q[$];
    vec_t vec_q[$];
    int   total = 0;
    int   bad = 0;

    ex_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_ex_i       (id_ex),
        .mem_stall_i   (mem_stall),
        .flush_i       (flush),
        .ex_mem_o      (ex_mem),
        .ex_busy_o     (ex_busy),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, want);
        end
    endtask

    function automatic id_ex_pipeline_reg_t mk(input alu_op_e op, input logic [31:0] pc,
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm, input logic src_imm,
        input br_op_e br, input logic branch, input logic jump, input logic jalr,
        input logic [4:0] rd, input logic vld);
        id_ex_pipeline_reg_t r;
        r             = '0;
        r.pc          = pc;
        r.rs1_data    = a;
        r.rs2_data    = b;
        r.imm         = imm;
        r.alu_op      = op;
        r.alu_src_imm = src_imm;
        r.br_op       = br;
        r.branch      = branch;
        r.jump        = jump;
        r.jalr        = jalr;
        r.rd_addr     = rd;
        r.reg_write   = 1'b1;
        r.valid       = vld;
        return r;
    endfunction

    task automatic add_vec(input id_ex_pipeline_reg_t s, input logic [31:0] res,
                           input logic redir, input logic [31:0] rpc, input logic rw);
        vec_t v;
        v.stim = s;
        v.ex   = '{valid: s.valid, res: res, rd: s.rd_addr, rw: rw, redir: redir, rpc: rpc};
        vec_q.push_back(v);
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got output with no expectation");
            return;
        end
        e = exp_q.pop_front();
        chk("valid", 32'(ex_mem.valid), 32'(e.valid));
        chk("redirect", 32'(redirect), 32'(e.redir));
        if (e.valid) begin
            chk("alu_result", ex_mem.alu_result, e.res);
            chk("rd_addr", 32'(ex_mem.rd_addr), 32'(e.rd));
            chk("reg_write", 32'(ex_mem.reg_write), 32'(e.rw));
        end
        if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
    endtask

`ifdef RV32_DIV_EN
    task automatic run_div(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] want, input int want_edges);
        int edges = 0;
        int busy_cnt = 0;
        id_ex = mk(op, 32'h400, a, b, 32'h0, 1'b0, BR_BEQ, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1);
        exp_q.push_back('{valid: 1'b1, res: want, rd: 5'd9, rw: 1'b1, redir: 1'b0, rpc: 32'h0});
        while (edges < 200) begin
            busy_cnt += int'(ex_busy);
            @(posedge clk);
            #1;
            edges++;
            if (ex_mem.valid) break;
        end
        id_ex = '0;
        chk("div_edges", 32'(edges), 32'(want_edges));
        chk("div_busy_cycles", 32'(busy_cnt), 32'(want_edges - 1));
        check_out();
    endtask
`endif

    initial begin
        int pulses;

        // Reset state
        #12;
        chk("rst_valid", 32'(ex_mem.valid), 32'h0);
        chk("rst_result", ex_mem.alu_result, 32'h0);
        chk("rst_redirect", 32'(redirect), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_busy", 32'(ex_busy), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-cycle vector table
        add_vec(mk(ALU_ADD, 0, 32'hFFFF_FFFF, 32'h1, 0, 0, BR_BEQ, 0, 0, 0, 5'd1, 1), 32'h0, 0, 0, 1);
        add_vec(mk(ALU_SUB, 0, 32'h0, 32'h1, 0, 0, BR_BEQ, 0, 0, 0, 5'd2, 1), 32'hFFFF_FFFF, 0, 0, 1);
        add_vec(mk(ALU_SLL, 0, 32'h1, 32'h21, 0, 0, BR_BEQ, 0, 0, 0, 5'd3, 1), 32'h2, 0, 0, 1);
        add_vec(mk(ALU_SRL, 0, 32'h8000_0000, 32'h4, 0, 0, BR_BEQ, 0, 0, 0, 5'd4, 1), 32'h0800_0000, 0, 0, 1);
        add_vec(mk(ALU_SRA, 0, 32'h8000_0000, 32'h4, 0, 0, BR_BEQ, 0, 0, 0, 5'd5, 1), 32'hF800_0000, 0, 0, 1);
        add_vec(mk(ALU_SLT, 0, 32'hFFFF_FFFF, 32'h1, 0, 0, BR_BEQ, 0, 0, 0, 5'd6, 1), 32'h1, 0, 0, 1);
        add_vec(mk(ALU_SLTU, 0, 32'hFFFF_FFFF, 32'h1, 0, 0, BR_BEQ, 0, 0, 0, 5'd7, 1), 32'h0, 0, 0, 1);
        add_vec(mk(ALU_XOR, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, BR_BEQ, 0, 0, 0, 5'd8, 1), 32'h0FF0_0FF0, 0, 0, 1);
        add_vec(mk(ALU_OR, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, BR_BEQ, 0, 0, 0, 5'd9, 1), 32'hFFF0_FFF0, 0, 0, 1);
        add_vec(mk(ALU_AND, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, BR_BEQ, 0, 0, 0, 5'd10, 1), 32'hF000_F000, 0, 0, 1);
        add_vec(mk(ALU_LUI, 0, 32'hDEAD_BEEF, 0, 32'h1234_5000, 1, BR_BEQ, 0, 0, 0, 5'd11, 1), 32'h1234_5000, 0, 0, 1);
        add_vec(mk(ALU_AUIPC, 32'h1000, 0, 0, 32'h2000, 1, BR_BEQ, 0, 0, 0, 5'd12, 1), 32'h3000, 0, 0, 1);
        add_vec(mk(ALU_ADD, 0, 32'd10, 32'd99, 32'd5, 1, BR_BEQ, 0, 0, 0, 5'd13, 1), 32'd15, 0, 0, 1);
        add_vec(mk(ALU_MUL, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, BR_BEQ, 0, 0, 0, 5'd14, 1), 32'h1, 0, 0, 1);
        add_vec(mk(ALU_MULH, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, BR_BEQ, 0, 0, 0, 5'd15, 1), 32'h0, 0, 0, 1);
        add_vec(mk(ALU_MULHSU, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, BR_BEQ, 0, 0, 0, 5'd16, 1), 32'hFFFF_FFFF, 0, 0, 1);
        add_vec(mk(ALU_MULHU, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, BR_BEQ, 0, 0, 0, 5'd17, 1), 32'hFFFF_FFFE, 0, 0, 1);
        add_vec(mk(ALU_MULH, 0, 32'h8000_0000, 32'h8000_0000, 0, 0, BR_BEQ, 0, 0, 0, 5'd18, 1), 32'h4000_0000, 0, 0, 1);
        add_vec(mk(ALU_MULHSU, 0, 32'h8000_0000, 32'h8000_0000, 0, 0, BR_BEQ, 0, 0, 0, 5'd19, 1), 32'hC000_0000, 0, 0, 1);
        add_vec(mk(ALU_SUB, 32'h100, 32'd5, 32'd5, 32'h20, 0, BR_BEQ, 1, 0, 0, 5'd20, 1), 32'h0, 1, 32'h120, 0);
        add_vec(mk(ALU_SUB, 32'h100, 32'd5, 32'd6, 32'h20, 0, BR_BEQ, 1, 0, 0, 5'd21, 1), 32'hFFFF_FFFF, 0, 0, 0);
        add_vec(mk(ALU_SUB, 32'h200, 32'd5, 32'd6, 32'hFFFF_FFF8, 0, BR_BNE, 1, 0, 0, 5'd22, 1), 32'hFFFF_FFFF, 1, 32'h1F8, 0);
        add_vec(mk(ALU_SUB, 32'h300, 32'hFFFF_FFFF, 32'h1, 32'h10, 0, BR_BLT, 1, 0, 0, 5'd23, 1), 32'hFFFF_FFFE, 1, 32'h310, 0);
        add_vec(mk(ALU_SUB, 32'h300, 32'hFFFF_FFFF, 32'h1, 32'h10, 0, BR_BLTU, 1, 0, 0, 5'd24, 1), 32'hFFFF_FFFE, 0, 0, 0);
        add_vec(mk(ALU_SUB, 32'h300, 32'h1, 32'hFFFF_FFFF, 32'h10, 0, BR_BGE, 1, 0, 0, 5'd25, 1), 32'h2, 1, 32'h310, 0);
        add_vec(mk(ALU_SUB, 32'h300, 32'h1, 32'hFFFF_FFFF, 32'h10, 0, BR_BGEU, 1, 0, 0, 5'd26, 1), 32'h2, 0, 0, 0);
        add_vec(mk(ALU_ADD, 32'h200, 0, 0, 32'h40, 0, BR_BEQ, 0, 1, 0, 5'd27, 1), 32'h204, 1, 32'h240, 1);
        add_vec(mk(ALU_ADD, 32'h300, 32'h203, 0, 32'h0, 0, BR_BEQ, 0, 0, 1, 5'd28, 1), 32'h304, 1, 32'h202, 1);
        add_vec(mk(ALU_ADD, 32'h500, 32'h1000, 0, 32'hFFFF_FFFF, 0, BR_BEQ, 0, 1, 1, 5'd29, 1), 32'h504, 1, 32'hFFE, 1);
        add_vec(mk(ALU_SUB, 32'h100, 32'd5, 32'd5, 32'h20, 0, BR_BEQ, 1, 0, 0, 5'd30, 0), 32'h0, 0, 0, 0);
`ifndef RV32_DIV_EN
        add_vec(mk(ALU_DIV, 0, 32'd7, 32'd2, 0, 0, BR_BEQ, 0, 0, 0, 5'd31, 1), 32'h0, 0, 0, 1);
        add_vec(mk(ALU_REMU, 0, 32'd7, 32'd2, 0, 0, BR_BEQ, 0, 0, 0, 5'd1, 1), 32'h0, 0, 0, 1);
`endif
        for (int i = 0; i < vec_q.size(); i++) begin
            id_ex = vec_q[i].stim;
            exp_q.push_back(vec_q[i].ex);
            chk("table_busy", 32'(ex_busy), 32'h0);
            @(posedge clk);
            #1;
            check_out();
        end
        id_ex = '0;

        // Flush kills a taken branch and its redirect
        id_ex = mk(ALU_SUB, 32'h100, 32'd5, 32'd5, 32'h20, 0, BR_BEQ, 1, 0, 0, 5'd4, 1);
        flush = 1'b1;
        exp_q.push_back('{valid: 1'b0, res: 32'h0, rd: 5'd0, rw: 1'b0, redir: 1'b0, rpc: 32'h0});
        @(posedge clk);
        #1;
        check_out();
        flush = 1'b0;

        // Stall held for 3 cycles while a taken branch sits in ex_mem_o
        id_ex = mk(ALU_SUB, 32'h100, 32'd5, 32'd5, 32'h20, 0, BR_BEQ, 1, 0, 0, 5'd6, 1);
        exp_q.push_back('{valid: 1'b1, res: 32'h0, rd: 5'd6, rw: 1'b0, redir: 1'b1, rpc: 32'h120});
        @(posedge clk);
        #1;
        check_out();
        id_ex = mk(ALU_ADD, 0, 32'd1, 32'd2, 0, 0, BR_BEQ, 0, 0, 0, 5'd7, 1);
        mem_stall = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_busy", 32'(ex_busy), 32'h1);
            @(posedge clk);
            #1;
            pulses += int'(redirect);
            chk("stall_hold_result", ex_mem.alu_result, 32'h0);
            chk("stall_hold_rd", 32'(ex_mem.rd_addr), 32'd6);
            chk("stall_hold_pc", redirect_pc, 32'h120);
        end
        chk("stall_redirect_repulse", 32'(pulses), 32'h0);
        mem_stall = 1'b0;
        exp_q.push_back('{valid: 1'b1, res: 32'd3, rd: 5'd7, rw: 1'b1, redir: 1'b0, rpc: 32'h0});
        chk("unstall_busy", 32'(ex_busy), 32'h0);
        @(posedge clk);
        #1;
        check_out();
        id_ex = '0;

`ifdef RV32_DIV_EN
        // Divider results and latency
        run_div(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_div(ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_div(ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_div(ALU_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_div(ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_div(ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_div(ALU_REMU, 32'd5, 32'd0, 32'd5, 2);
        run_div(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_div(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

        // Flush at cycle 10 of a division
        id_ex = mk(ALU_DIVU, 32'h400, 32'd100, 32'd7, 0, 0, BR_BEQ, 0, 0, 0, 5'd9, 1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("div_bubble_valid", 32'(ex_mem.valid), 32'h0);
        end
        flush = 1'b1;
        chk("flush_busy", 32'(ex_busy), 32'h0);
        exp_q.push_back('{valid: 1'b0, res: 32'h0, rd: 5'd0, rw: 1'b0, redir: 1'b0, rpc: 32'h0});
        @(posedge clk);
        #1;
        check_out();
        flush = 1'b0;
        id_ex = mk(ALU_ADD, 0, 32'd2, 32'd3, 0, 0, BR_BEQ, 0, 0, 0, 5'd3, 1);
        exp_q.push_back('{valid: 1'b1, res: 32'd5, rd: 5'd3, rw: 1'b1, redir: 1'b0, rpc: 32'h0});
        @(posedge clk);
        #1;
        check_out();
        id_ex = '0;
        run_div(ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);

        // Reset mid-division
        id_ex = mk(ALU_SUB, 32'h100, 32'd5, 32'd5, 32'h20, 0, BR_BEQ, 1, 0, 0, 5'd6, 1);
        exp_q.push_back('{valid: 1'b1, res: 32'h0, rd: 5'd6, rw: 1'b0, redir: 1'b1, rpc: 32'h120});
        @(posedge clk);
        #1;
        check_out();
        id_ex = mk(ALU_DIV, 32'h400, 32'hFFFF_FFF9, 32'd2, 0, 0, BR_BEQ, 0, 0, 0, 5'd9, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        id_ex = '0;
        #1;
        chk("midrst_valid", 32'(ex_mem.valid), 32'h0);
        chk("midrst_result", ex_mem.alu_result, 32'h0);
        chk("midrst_redirect", 32'(redirect), 32'h0);
        chk("midrst_redirect_pc", redirect_pc, 32'h0);
        chk("midrst_busy", 32'(ex_busy), 32'h0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_div(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
